// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller and its message checker.
package rc4_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_GO, S_INIT_WAIT, S_INIT_ACK,
    S_KSA_GO, S_KSA_WAIT, S_KSA_ACK,
    S_PRGA_GO, S_PRGA_WAIT, S_PRGA_ACK,
    S_CHK_GO, S_CHK_WAIT, S_NEXT_KEY, S_FOUND, S_FAIL
  } state_t;

  typedef enum logic [1:0] {CK_IDLE, CK_ADDR, CK_WAIT, CK_EVAL} chk_state_t;

  localparam logic [1:0] MSEL_INIT  = 2'd0;
  localparam logic [1:0] MSEL_SHUFA = 2'd1;
  localparam logic [1:0] MSEL_SHUFB = 2'd2;
  localparam logic [1:0] MSEL_CHK   = 2'd3;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  localparam int MSG_LEN_DEF = 32;

  function automatic logic is_msg_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
  endfunction

endpackage

// File: rtl/rc4_msg_checker.sv
// Scans decrypted RAM byte by byte (2-cycle read latency), aborting on the first byte
// that is not lowercase/space; reports chk_done with chk_pass one cycle after the verdict.
module rc4_msg_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chk_start,
  input  logic [7:0] q_D,
  output logic [4:0] chk_addr_D,
  output logic       chk_done,
  output logic       chk_pass
);

  localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);

  chk_state_t st, st_nxt;
  logic [4:0] addr, addr_nxt;
  logic       done_nxt, pass_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= CK_IDLE;
      addr     <= '0;
      chk_done <= 1'b0;
      chk_pass <= 1'b0;
    end else begin
      st       <= st_nxt;
      addr     <= addr_nxt;
      chk_done <= done_nxt;
      chk_pass <= pass_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    addr_nxt = addr;
    done_nxt = 1'b0;
    pass_nxt = 1'b0;
    case (st)
      CK_IDLE: if (chk_start) begin
        st_nxt   = CK_ADDR;
        addr_nxt = '0;
      end
      CK_ADDR: st_nxt = CK_WAIT;
      CK_WAIT: st_nxt = CK_EVAL;
      CK_EVAL: begin
        // Address parks at 0 once a verdict is reached so the next scan starts clean.
        if (!is_msg_char(q_D)) begin
          st_nxt   = CK_IDLE;
          addr_nxt = '0;
          done_nxt = 1'b1;
        end else if (addr == LAST_IDX) begin
          st_nxt   = CK_IDLE;
          addr_nxt = '0;
          done_nxt = 1'b1;
          pass_nxt = 1'b1;
        end else begin
          st_nxt   = CK_ADDR;
          addr_nxt = addr + 5'd1;
        end
      end
      default: st_nxt = CK_IDLE;
    endcase
  end

  assign chk_addr_D = addr;

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force sequencer: per key runs S-init, KSA, PRGA handshakes then the message checker.
// Optional handshake watchdog enabled by defining RC4_HANDSHAKE_TIMEOUT_EN.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF,
  parameter int               MSG_LEN   = MSG_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             init_start,
  input  logic             init_finish,
  output logic             init_ack,
  output logic             shufA_start,
  input  logic             shufA_finish,
  output logic             shufA_ack,
  output logic             shufB_start,
  input  logic             shufB_finish,
  output logic             shufB_ack,
  output logic [1:0]       mem_sel,
  output logic [KEY_W-1:0] secret_key,
  output logic [4:0]       chk_addr_D,
  input  logic [7:0]       q_D,
  output logic             busy,
  output logic             done,
  output logic             key_found,
  output logic             timeout_err
);

  state_t           st, st_nxt;
  logic [1:0]       msel_nxt;
  logic [KEY_W-1:0] key_nxt;
  logic             wait_fin, tmo_hit;
  logic             chk_start, chk_done, chk_pass;

  rc4_msg_checker #(.MSG_LEN(MSG_LEN)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .chk_start  (chk_start),
    .q_D        (q_D),
    .chk_addr_D (chk_addr_D),
    .chk_done   (chk_done),
    .chk_pass   (chk_pass)
  );

  assign wait_fin = ((st == S_INIT_WAIT) && init_finish) ||
                    ((st == S_KSA_WAIT)  && shufA_finish) ||
                    ((st == S_PRGA_WAIT) && shufB_finish);

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      mem_sel    <= MSEL_INIT;
      secret_key <= KEY_START;
    end else begin
      st         <= st_nxt;
      mem_sel    <= msel_nxt;
      secret_key <= key_nxt;
    end
  end

`ifdef RC4_HANDSHAKE_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        in_wait;

  assign in_wait = st inside {S_INIT_WAIT, S_KSA_WAIT, S_PRGA_WAIT};
  assign tmo_hit = in_wait && !wait_fin && (tmo_cnt == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (st inside {S_INIT_GO, S_KSA_GO, S_PRGA_GO}) tmo_cnt <= '0;
      else if (in_wait)                               tmo_cnt <= tmo_cnt + 16'd1;
      if (tmo_hit)            timeout_err <= 1'b1;
      else if (start && !busy) timeout_err <= 1'b0;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // mem_sel moves only on entry to a *_GO state, so an engine never loses its RAM mid-run.
  always_comb begin
    st_nxt   = st;
    msel_nxt = mem_sel;
    key_nxt  = secret_key;
    case (st)
      S_IDLE, S_FOUND, S_FAIL: if (start) begin
        st_nxt   = S_INIT_GO;
        msel_nxt = MSEL_INIT;
        key_nxt  = KEY_START;
      end
      S_INIT_GO:   st_nxt = S_INIT_WAIT;
      S_INIT_WAIT: if (wait_fin) st_nxt = S_INIT_ACK;
      S_INIT_ACK: begin
        st_nxt   = S_KSA_GO;
        msel_nxt = MSEL_SHUFA;
      end
      S_KSA_GO:    st_nxt = S_KSA_WAIT;
      S_KSA_WAIT:  if (wait_fin) st_nxt = S_KSA_ACK;
      S_KSA_ACK: begin
        st_nxt   = S_PRGA_GO;
        msel_nxt = MSEL_SHUFB;
      end
      S_PRGA_GO:   st_nxt = S_PRGA_WAIT;
      S_PRGA_WAIT: if (wait_fin) st_nxt = S_PRGA_ACK;
      S_PRGA_ACK: begin
        st_nxt   = S_CHK_GO;
        msel_nxt = MSEL_CHK;
      end
      S_CHK_GO:    st_nxt = S_CHK_WAIT;
      S_CHK_WAIT:  if (chk_done) st_nxt = chk_pass ? S_FOUND : S_NEXT_KEY;
      S_NEXT_KEY: begin
        if (secret_key == KEY_END) begin
          st_nxt = S_FAIL;
        end else begin
          st_nxt   = S_INIT_GO;
          msel_nxt = MSEL_INIT;
          key_nxt  = secret_key + 1'b1;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
    if (tmo_hit) begin
      st_nxt  = S_FAIL;
      key_nxt = KEY_END;
    end
  end

  assign init_start  = (st == S_INIT_GO);
  assign init_ack    = (st == S_INIT_ACK);
  assign shufA_start = (st == S_KSA_GO);
  assign shufA_ack   = (st == S_KSA_ACK);
  assign shufB_start = (st == S_PRGA_GO);
  assign shufB_ack   = (st == S_PRGA_ACK);
  assign chk_start   = (st == S_CHK_GO);
  assign done        = (st == S_FOUND) || (st == S_FAIL);
  assign key_found   = (st == S_FOUND);
  assign busy        = !((st == S_IDLE) || done);

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Scoreboard bench: stimulus queues expected scan/result records, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_rc4_key_search_ctrl;

  typedef struct packed {logic found; logic [23:0] key; logic terr;} res_t;
  typedef struct packed {logic [23:0] key; logic [4:0] maxa;} scan_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [5:0]  e_start, e_ack, e_finish, e_stall;
  logic [1:0]  msel_a, msel_b;
  logic [23:0] key_a, key_b;
  logic [4:0]  addr_a, addr_b;
  logic [7:0]  q_a, q_b, r1_a;
  logic        busy_a, done_a, found_a, terr_a;
  logic        busy_b, done_b, found_b, terr_b;
  int          mode;

  rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'd0), .KEY_END(24'd7), .MSG_LEN(32)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .init_start(e_start[0]), .init_finish(e_finish[0]), .init_ack(e_ack[0]),
    .shufA_start(e_start[1]), .shufA_finish(e_finish[1]), .shufA_ack(e_ack[1]),
    .shufB_start(e_start[2]), .shufB_finish(e_finish[2]), .shufB_ack(e_ack[2]),
    .mem_sel(msel_a), .secret_key(key_a), .chk_addr_D(addr_a), .q_D(q_a),
    .busy(busy_a), .done(done_a), .key_found(found_a), .timeout_err(terr_a));

  rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'd5), .KEY_END(24'd5), .MSG_LEN(32)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .init_start(e_start[3]), .init_finish(e_finish[3]), .init_ack(e_ack[3]),
    .shufA_start(e_start[4]), .shufA_finish(e_finish[4]), .shufA_ack(e_ack[4]),
    .shufB_start(e_start[5]), .shufB_finish(e_finish[5]), .shufB_ack(e_ack[5]),
    .mem_sel(msel_b), .secret_key(key_b), .chk_addr_D(addr_b), .q_D(q_b),
    .busy(busy_b), .done(done_b), .key_found(found_b), .timeout_err(terr_b));

  // Engine models: finish 5 cycles after start, held until ack (or never, when stalled).
  logic [2:0] e_cnt [6];
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        e_cnt[i]    <= '0;
        e_finish[i] <= 1'b0;
      end else begin
        if (e_ack[i]) e_finish[i] <= 1'b0;
        if (e_start[i]) e_cnt[i] <= 3'd5;
        else if (e_cnt[i] == 3'd1) begin
          e_cnt[i] <= '0;
          if (!e_stall[i]) e_finish[i] <= 1'b1;
        end else if (e_cnt[i] != 3'd0) e_cnt[i] <= e_cnt[i] - 3'd1;
      end
    end
  end

  function automatic logic [7:0] ram_byte(input int m, input logic [23:0] k, input logic [4:0] a);
    case (m)
      1: return 8'h61;
      2: return (k < 24'd3 && a == 5'd3) ? 8'h41 : 8'h61;
      5: return (a == 5'd31) ? 8'h20 : 8'h7A;
      default: return 8'h00;
    endcase
  endfunction

  // Decrypted RAM with two-cycle read latency; DUT b's message is never valid.
  always @(posedge clk) begin
    r1_a <= ram_byte(mode, key_a, addr_a);
    q_a  <= r1_a;
  end
  assign q_b = 8'h13;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  res_t  res_qa[$], res_qb[$];
  scan_t scan_qa[$], scan_qb[$];

  logic        dq_a, dq_b, sc_a, sc_b;
  logic [4:0]  mx_a, mx_b;
  logic [23:0] sk_a, sk_b;
  int          pw [12];
  int          pcnt [6];
  logic [11:0] hs;
  assign hs = {e_ack, e_start};

  initial begin
    for (int i = 0; i < 6; i++) pcnt[i] = 0;
  end

  always @(negedge clk) begin
    res_t  r;
    scan_t s;
    if (rst) begin
      dq_a = 1'b0; dq_b = 1'b0; sc_a = 1'b0; sc_b = 1'b0;
      for (int i = 0; i < 12; i++) pw[i] = 0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (hs[i]) begin
          if (pw[i] == 0 && i < 6) pcnt[i]++;
          pw[i]++;
        end else begin
          if (pw[i] != 0) check("pulse_width", pw[i], 1);
          pw[i] = 0;
        end
      end
      // DUT a scan tracking
      if (msel_a == 2'd3 && !done_a) begin
        if (!sc_a) begin sc_a = 1'b1; mx_a = '0; end
        if (addr_a > mx_a) mx_a = addr_a;
        sk_a = key_a;
      end else if (sc_a) begin
        sc_a = 1'b0;
        if (scan_qa.size() == 0) begin total++; bad++; $display("FAIL scan_a: unexpected scan key=%0d", sk_a); end
        else begin
          s = scan_qa.pop_front();
          check("scan_a_key", sk_a, s.key);
          check("scan_a_last_addr", mx_a, s.maxa);
        end
      end
      if (done_a && !dq_a) begin
        if (res_qa.size() == 0) begin total++; bad++; $display("FAIL res_a: unexpected done"); end
        else begin
          r = res_qa.pop_front();
          check("res_a_found", found_a, r.found);
          check("res_a_key", key_a, r.key);
          check("res_a_terr", terr_a, r.terr);
          check("res_a_busy", busy_a, 0);
        end
      end
      dq_a = done_a;
      // DUT b scan tracking
      if (msel_b == 2'd3 && !done_b) begin
        if (!sc_b) begin sc_b = 1'b1; mx_b = '0; end
        if (addr_b > mx_b) mx_b = addr_b;
        sk_b = key_b;
      end else if (sc_b) begin
        sc_b = 1'b0;
        if (scan_qb.size() == 0) begin total++; bad++; $display("FAIL scan_b: unexpected scan key=%0d", sk_b); end
        else begin
          s = scan_qb.pop_front();
          check("scan_b_key", sk_b, s.key);
          check("scan_b_last_addr", mx_b, s.maxa);
        end
      end
      if (done_b && !dq_b) begin
        if (res_qb.size() == 0) begin total++; bad++; $display("FAIL res_b: unexpected done"); end
        else begin
          r = res_qb.pop_front();
          check("res_b_found", found_b, r.found);
          check("res_b_key", key_b, r.key);
          check("res_b_terr", terr_b, r.terr);
          check("res_b_busy", busy_b, 0);
        end
      end
      dq_b = done_b;
    end
  end

  task automatic wait_done(input int which, input int bound, input string name);
    int n = 0;
    while (!(which == 0 ? done_a : done_b) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      total++; bad++;
      $display("FAIL %s: done not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  logic [16:0] outs_a;
  assign outs_a = {e_start[2:0], e_ack[2:0], busy_a, done_a, found_a, terr_a, msel_a, addr_a};

  initial begin
    int p0, n;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1; e_stall = '0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", outs_a, 0);
    check("reset_key_a", key_a, 0);
    check("reset_key_b", key_b, 5);
    check("reset_done_b", {busy_b, done_b, found_b, terr_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: all 'a' at key 0 -> found after one pass
    mode = 1;
    p0 = pcnt[0] + pcnt[1] + pcnt[2];
    scan_qa.push_back('{key: 24'd0, maxa: 5'd31});
    res_qa.push_back('{found: 1'b1, key: 24'd0, terr: 1'b0});
    pulse_start_a();
    check("t1_busy", busy_a, 1);
    wait_done(0, 2000, "t1_done");
    check("t1_start_pulses", pcnt[0] + pcnt[1] + pcnt[2] - p0, 3);

    // 2: byte 3 bad for keys 0..2 -> three early aborts, found at key 3
    mode = 2;
    for (int k = 0; k < 3; k++) scan_qa.push_back('{key: 24'(k), maxa: 5'd3});
    scan_qa.push_back('{key: 24'd3, maxa: 5'd31});
    res_qa.push_back('{found: 1'b1, key: 24'd3, terr: 1'b0});
    pulse_start_a();
    wait_done(0, 3000, "t2_done");

    // 3: single-key range, never valid -> exhausted
    scan_qb.push_back('{key: 24'd5, maxa: 5'd0});
    res_qb.push_back('{found: 1'b0, key: 24'd5, terr: 1'b0});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1, 2000, "t3_done");

    // 4: start ignored in KSA_WAIT, then reset in PRGA_WAIT
    mode = 4;
    scan_qa.push_back('{key: 24'd0, maxa: 5'd0});
    scan_qa.push_back('{key: 24'd1, maxa: 5'd0});
    pulse_start_a();
    n = 0;
    while (!(e_start[1] && key_a == 24'd2) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin total++; bad++; $display("FAIL t4_ksa: key 2 KSA start not seen"); end
    @(negedge clk);
    p0 = pcnt[0];
    pulse_start_a();
    repeat (2) @(negedge clk);
    check("t4_ignored_key", key_a, 2);
    check("t4_ignored_busy", busy_a, 1);
    check("t4_ignored_init", pcnt[0] - p0, 0);
    n = 0;
    while (!e_start[2] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total++; bad++; $display("FAIL t4_prga: PRGA start not seen"); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_outs", outs_a, 0);
    check("t4_rst_key", key_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // 5: 'z' bytes with trailing space -> found; restart from FOUND
    mode = 5;
    scan_qa.push_back('{key: 24'd0, maxa: 5'd31});
    res_qa.push_back('{found: 1'b1, key: 24'd0, terr: 1'b0});
    pulse_start_a();
    wait_done(0, 2000, "t5_done");
    scan_qa.push_back('{key: 24'd0, maxa: 5'd31});
    res_qa.push_back('{found: 1'b1, key: 24'd0, terr: 1'b0});
    pulse_start_a();
    check("t5_restart_done", done_a, 0);
    check("t5_restart_found", found_a, 0);
    check("t5_restart_init", e_start[0], 1);
    wait_done(0, 2000, "t5_done2");

`ifdef RC4_HANDSHAKE_TIMEOUT_EN
    // 6: KSA engine never finishes -> watchdog fail
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e_stall[1] = 1'b1;
    res_qa.push_back('{found: 1'b0, key: 24'd7, terr: 1'b1});
    pulse_start_a();
    n = 0;
    while (!e_start[1] && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!done_a && n < 70000) begin @(negedge clk); n++; end
    check("t6_wait_cycles_in_range", (n >= 65535 && n <= 65540), 1);
    e_stall[1] = 1'b0;
    pulse_start_a();
    check("t6_terr_cleared", terr_a, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("pending_scan_a", scan_qa.size(), 0);
    check("pending_res_a", res_qa.size(), 0);
    check("pending_scan_b", scan_qb.size(), 0);
    check("pending_res_b", res_qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
